fpu_arbiter: RTL
================

# fpu_arbiter

Shares one `fpu` instance between N requesters (e.g. integer pipeline, vector unit, debug port) using round-robin arbitration. Each request is a complete transaction: the block latches command and operands, drives the FPU input handshake, collects the result through the FPU output handshake, and returns it to the owning requester. Only one operation is in flight at a time. The block sits between the requesters and the FPU's `command`/`data_a`/`data_b`/`input_rdy`/`input_ack`/`result`/`output_rdy`/`output_ack` ports.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 255: watchdog limit in cycles; used only with `FPU_ARB_TIMEOUT_EN`.
- `clock`  input  1  single clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `req`  input  N_REQ  per-requester request level; held until `grant[i]`.
- `req_command`  input  4*N_REQ  command of requester i at bits [4i+3:4i].
- `req_a`, `req_b`  input  32*N_REQ  operands of requester i at bits [32i+31:32i].
- `grant`  output  N_REQ  one-cycle one-hot pulse when the request is latched.
- `resp_valid`  output  N_REQ  one-hot; the result is valid for the owner.
- `resp_result`  output  32  result, shared by all requesters.
- `resp_err`  output  1  timeout flag, qualified by `resp_valid`.
- `resp_ack`  input  N_REQ  owner consumes the result.
- `busy`  output  1  high in any state other than IDLE.
- `fpu_command`  output  4;  `fpu_a`, `fpu_b`  output  32: latched request fields.
- `fpu_input_rdy`  output  1;  `fpu_input_ack`  input  1.
- `fpu_result`  input  32;  `fpu_output_rdy`  input  1;  `fpu_output_ack`  output  1.

## Operation
- States:
  - IDLE → ISSUE → WAIT → RELEASE → RESPOND → IDLE.
- Reset values:
  - All outputs 0; state IDLE.
  - Round-robin pointer `last` = N_REQ-1, so requester 0 has first priority.
- IDLE:
  - If any `req` bit is high, select the first set bit searching upward (with wrap) from `last+1`.
  - Latch its command and operands into `fpu_command`/`fpu_a`/`fpu_b` and record the owner.
  - Pulse `grant[owner]` in the next cycle. Go to ISSUE.
- ISSUE:
  - `fpu_input_rdy`=1 with stable latched operands.
  - On an edge where `fpu_input_ack`=1, go to WAIT and drop `fpu_input_rdy`.
- WAIT:
  - On an edge where `fpu_output_rdy`=1, capture `fpu_result` into `resp_result` and go to RELEASE.
- RELEASE:
  - `fpu_output_ack`=1.
  - Stay while `fpu_output_rdy`=1. When it is sampled 0, drop `fpu_output_ack` and go to RESPOND.
- RESPOND:
  - `resp_valid[owner]`=1 with `resp_result` held.
  - On `resp_ack[owner]`=1: clear `resp_valid`, set `last`=owner, go to IDLE.
  - `resp_ack` bits of non-owners are ignored.
- Requests that arrive while busy are not latched. They remain pending and are arbitrated on return to IDLE.
- If a requester drops `req` before `grant`, the behaviour is undefined, because its operands are latched at the arbitration edge.
- If `reset` is asserted in any state, the block returns to IDLE and all outputs clear immediately. The in-flight transaction is lost; the FPU must also be reset.

## Timing
- Arbitration: 1 cycle (IDLE to ISSUE). `grant` is high in the first ISSUE cycle.
- Minimum request-to-`resp_valid` latency is 5 cycles, assuming `fpu_input_ack` and `fpu_output_rdy` respond immediately and `fpu_output_rdy` falls one cycle after `fpu_output_ack`.
- Back-to-back throughput: IDLE costs one cycle between transactions. There is no bypass.
- Fairness: a continuously requesting requester is served at least once every N_REQ transactions.

## Configuration
- `FPU_ARB_TIMEOUT_EN` defined:
  - An 8-bit-or-wider watchdog counter runs in ISSUE and WAIT and clears on each state change.
  - When it reaches `TIMEOUT`, the block drops `fpu_input_rdy`, sets `resp_result`=32'hFFFFFFFF and `resp_err`=1, and goes directly to RESPOND.
  - `resp_err` clears on `resp_ack`.
- `FPU_ARB_TIMEOUT_EN` not defined:
  - No counter is built. `resp_err` is tied to 0, and the block waits indefinitely.

## Test plan
- Single request: requester 0, command 4'h0, a=32'h3F800000, b=32'h3C23D70A. The behavioural FPU returns 32'h3F8147AE after 3 cycles. Required: `grant`=4'b0001 pulse; `resp_valid`=4'b0001; `resp_result`=32'h3F8147AE within 8 cycles; `busy` drops after `resp_ack`.
- Round robin: all four `req` held high for 8 transactions. Required grant order: 0,1,2,3,0,1,2,3.
- Pointer wrap: after serving requester 2, raise only `req[1]` and `req[3]`. Required: 3 is served, then 1.
- Handshake stress: FPU delays `input_ack` by 4 cycles and holds `output_rdy` for 3 cycles after `output_ack`. Required: `fpu_input_rdy` and operands stay stable until `input_ack`; `fpu_output_ack` stays high until `output_rdy` falls; exactly one response is returned.
- Reset mid-WAIT: assert `reset` low. Required: all outputs are 0 immediately, and the next request after release is granted to requester 0.
- With `FPU_ARB_TIMEOUT_EN` and `TIMEOUT`=16: the FPU never asserts `output_rdy`. Required: `resp_valid` rises with `resp_result`=32'hFFFFFFFF and `resp_err`=1 at cycle 16 of WAIT.

Source files
------------

// File: rtl/fpu_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_arbiter
//
// Shares a single FPU between N_REQ requesters with round-robin arbitration.
// Each grant is a complete transaction: latch the command/operands, run the
// FPU input handshake, collect the result through the FPU output handshake,
// then present the result to the owner until it acknowledges. Only one
// operation is ever in flight.
//
// Optional feature macro: FPU_ARB_TIMEOUT_EN
//   defined     - a watchdog aborts ISSUE/WAIT after TIMEOUT cycles and
//                 returns 32'hFFFFFFFF with resp_err=1.
//   not defined - no watchdog; resp_err is tied low; waits indefinitely.
//
// Parameters
//   N_REQ    number of requesters (2..8)
//   TIMEOUT  watchdog limit in cycles (only with FPU_ARB_TIMEOUT_EN)
//
// Ports
//   clock, reset          clock (rising edge), async active-low reset
//   req                   per-requester request level, held until grant
//   req_command           4-bit command of requester i at [4i+3:4i]
//   req_a, req_b          32-bit operands of requester i at [32i+31:32i]
//   grant                 one-cycle one-hot pulse when a request is latched
//   resp_valid            one-hot, result valid for the owner
//   resp_result           shared result bus
//   resp_err              timeout flag, qualified by resp_valid
//   resp_ack              owner consumes the result
//   busy                  high whenever not IDLE
//   fpu_command/a/b       latched request fields toward the FPU
//   fpu_input_rdy/ack     FPU input handshake
//   fpu_result            FPU result
//   fpu_output_rdy/ack    FPU output handshake
// -----------------------------------------------------------------------------
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | arbitrate pending requests, latch winner
// S_ISSUE   | fpu_input_rdy high, wait for fpu_input_ack
// S_WAIT    | wait for fpu_output_rdy, capture result
// S_RELEASE | fpu_output_ack high until fpu_output_rdy falls
// S_RESPOND | resp_valid[owner] high until resp_ack[owner]

module fpu_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [4*N_REQ-1:0]    req_command,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      grant,
  output logic [N_REQ-1:0]      resp_valid,
  output logic [31:0]           resp_result,
  output logic                  resp_err,
  input  logic [N_REQ-1:0]      resp_ack,
  output logic                  busy,
  output logic [3:0]            fpu_command,
  output logic [31:0]           fpu_a,
  output logic [31:0]           fpu_b,
  output logic                  fpu_input_rdy,
  input  logic                  fpu_input_ack,
  input  logic [31:0]           fpu_result,
  input  logic                  fpu_output_rdy,
  output logic                  fpu_output_ack
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_RESPOND = 3'd4;

  logic [2:0]    state;
  logic [IW-1:0] last;
  logic [IW-1:0] owner;

  logic [IW-1:0] pick;
  logic [IW-1:0] idx;
  logic          pick_valid;
  logic          timeout_hit;

  logic [3:0]  cmd_arr [N_REQ];
  logic [31:0] a_arr   [N_REQ];
  logic [31:0] b_arr   [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign cmd_arr[g] = req_command[4*g +: 4];
    assign a_arr[g]   = req_a[32*g +: 32];
    assign b_arr[g]   = req_b[32*g +: 32];
  end

  // Round-robin search: first set req bit starting just above the last owner.
  always_comb begin
    pick       = last;
    idx        = last;
    pick_valid = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IW'((int'(last) + k) % N_REQ);
      if (!pick_valid && req[idx]) begin
        pick       = idx;
        pick_valid = 1'b1;
      end
    end
  end

  assign busy           = (state != S_IDLE);
  assign fpu_input_rdy  = (state == S_ISSUE);
  assign fpu_output_ack = (state == S_RELEASE);
  assign resp_valid     = (state == S_RESPOND) ? (N_REQ'(1) << owner) : '0;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] wd_cnt;
  logic          wd_active;
  logic          progress;

  assign wd_active = (state == S_ISSUE) || (state == S_WAIT);
  // A handshake completing on the same edge as expiry wins over the abort.
  assign progress  = ((state == S_ISSUE) && fpu_input_ack) ||
                     ((state == S_WAIT)  && fpu_output_rdy);
  // wd_cnt counts completed cycles in the current state, so the abort edge
  // is the one closing the TIMEOUT-th cycle.
  assign timeout_hit = wd_active && !progress && (wd_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (!wd_active || progress || timeout_hit) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_err <= 1'b0;
    end else if (timeout_hit) begin
      resp_err <= 1'b1;
    end else if ((state == S_RESPOND) && resp_ack[owner]) begin
      resp_err <= 1'b0;
    end
  end
`else
  logic unused_timeout;
  // TIMEOUT only matters when the watchdog is built.
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
  assign resp_err       = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      last        <= IW'(N_REQ - 1);
      owner       <= '0;
      grant       <= '0;
      resp_result <= '0;
      fpu_command <= '0;
      fpu_a       <= '0;
      fpu_b       <= '0;
    end else begin
      grant <= '0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            owner       <= pick;
            fpu_command <= cmd_arr[pick];
            fpu_a       <= a_arr[pick];
            fpu_b       <= b_arr[pick];
            grant       <= N_REQ'(1) << pick;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (fpu_input_ack) begin
            state <= S_WAIT;
          end else if (timeout_hit) begin
            resp_result <= 32'hFFFF_FFFF;
            state       <= S_RESPOND;
          end
        end
        S_WAIT: begin
          if (fpu_output_rdy) begin
            resp_result <= fpu_result;
            state       <= S_RELEASE;
          end else if (timeout_hit) begin
            resp_result <= 32'hFFFF_FFFF;
            state       <= S_RESPOND;
          end
        end
        S_RELEASE: begin
          if (!fpu_output_rdy) begin
            state <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          if (resp_ack[owner]) begin
            last  <= owner;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
